// File: rtl/hazard_tag_pipe.sv
// hazard_tag_pipe: control/tag pipeline registers for the five-stage MIPS core.
// Holds PCF, the IF/ID instruction, the ID/EX tags and controls, and the EX/MEM
// and MEM/WB destination/control fields that the hazard unit reads back.
// Optional build macro: HAZARD_STATS_EN adds saturating stall/flush counters.
module hazard_tag_pipe #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushE,
    input  logic        PCSrcD,
    input  logic [31:0] PCNextF,
    input  logic [31:0] InstrF,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        RegDstD,
    input  logic [2:0]  ALUControlD,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [4:0]  RsD,
    output logic [4:0]  RtD,
    output logic [4:0]  RdD,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic [2:0]  ALUControlE,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic [4:0]  WriteRegE,
    output logic        RegWriteM,
    output logic        MemtoRegM,
    output logic [4:0]  WriteRegM,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
`endif
);

    logic regDstE;

    // Fetch PC: hold while fetch is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            PCF <= PCNextF;
        end
    end

    // IF/ID: a stall holds the instruction even when a branch redirect is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD <= '0;
        end else if (!StallD) begin
            InstrD <= PCSrcD ? '0 : InstrF;
        end
    end

    assign RsD = InstrD[25:21];
    assign RtD = InstrD[20:16];
    assign RdD = InstrD[15:11];

    // ID/EX: always clocked; a flush loads an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
            ALUControlE <= '0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            regDstE     <= 1'b0;
        end else if (FlushE) begin
            RsE         <= '0;
            RtE         <= '0;
            RdE         <= '0;
            ALUControlE <= '0;
            RegWriteE   <= 1'b0;
            MemtoRegE   <= 1'b0;
            regDstE     <= 1'b0;
        end else begin
            RsE         <= RsD;
            RtE         <= RtD;
            RdE         <= RdD;
            ALUControlE <= ALUControlD;
            RegWriteE   <= RegWriteD;
            MemtoRegE   <= MemtoRegD;
            regDstE     <= RegDstD;
        end
    end

    assign WriteRegE = regDstE ? RdE : RtE;

    // EX/MEM and MEM/WB: always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            WriteRegM <= '0;
            RegWriteW <= 1'b0;
            WriteRegW <= '0;
        end else begin
            RegWriteM <= RegWriteE;
            MemtoRegM <= MemtoRegE;
            WriteRegM <= WriteRegE;
            RegWriteW <= RegWriteM;
            WriteRegW <= WriteRegM;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating counts of decode-stall and execute-flush edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallD && (StallCount != '1)) begin
                StallCount <= StallCount + 16'd1;
            end
            if (FlushE && (FlushCount != '1)) begin
                FlushCount <= FlushCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/hazard_tag_pipe.md
# hazard_tag_pipe

Pipeline-register bank for the control and register-tag fields of the five-stage MIPS core. It consumes the hazard unit's stall and flush commands (StallF, StallD, FlushE) together with the branch redirect. It produces the per-stage tags and control bits the hazard unit reads back: RsD/RtD/RdD, RsE/RtE/RdE, ALUControlE, RegWrite/MemtoReg per stage, and WriteRegE/M/W. The datapath value registers sit beside this block and use the same enables.

## Interface
- RESET_PC, default 32'h0000_0000, PCF value after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- StallF  in  1  hold PCF
- StallD  in  1  hold the IF/ID register
- FlushE  in  1  load a bubble into the ID/EX register
- PCSrcD  in  1  branch taken in D; squash the instruction in IF/ID
- PCNextF  in  32  next PC
- InstrF  in  32  fetched instruction
- RegWriteD  in  1  decode control
- MemtoRegD  in  1  decode control
- RegDstD  in  1  1 selects rd as destination, 0 selects rt
- ALUControlD  in  3  decode ALU op (3'b101 = WGHT)
- PCF  out  32  fetch PC
- InstrD  out  32  decode instruction
- RsD  out  5  InstrD[25:21]
- RtD  out  5  InstrD[20:16]
- RdD  out  5  InstrD[15:11]
- RsE  out  5  execute-stage source tag
- RtE  out  5  execute-stage source tag
- RdE  out  5  execute-stage tag; also the third WGHT source
- ALUControlE  out  3  execute ALU op
- RegWriteE  out  1  execute control
- MemtoRegE  out  1  execute control
- WriteRegE  out  5  RegDstE ? RdE : RtE (combinational)
- RegWriteM  out  1  memory control
- MemtoRegM  out  1  memory control
- WriteRegM  out  5  memory destination
- RegWriteW  out  1  writeback control
- WriteRegW  out  5  writeback destination
- StallCount  out  16  present only with HAZARD_STATS_EN
- FlushCount  out  16  present only with HAZARD_STATS_EN

## Operation
- **Fetch register:** PCF <= StallF ? PCF : PCNextF.
- **IF/ID register:**
  - StallD=1: hold InstrD. StallD takes priority over PCSrcD.
  - StallD=0, PCSrcD=1: InstrD <= 32'h0 (nop).
  - Otherwise: InstrD <= InstrF.
- **RsD/RtD/RdD:** combinational field slices of InstrD.
- **ID/EX register:** always clocked; StallD does not gate it.
  - FlushE=1: RsE, RtE, RdE, ALUControlE, RegWriteE, MemtoRegE and RegDstE all load 0.
  - FlushE=0: each field loads its D-stage counterpart.
- **Bubble semantics:** a bubble has RegWriteE=0, so it never causes forwarding.
- **Stall pattern:** the hazard unit asserts StallF, StallD and FlushE together. Required result: PCF and InstrD hold, E receives a bubble, M and W advance.
- **EX/MEM register:** always advances. RegWriteM <= RegWriteE, MemtoRegM <= MemtoRegE, WriteRegM <= WriteRegE.
- **MEM/WB register:** always advances. RegWriteW <= RegWriteM, WriteRegW <= WriteRegM.
- **Decode with no instruction:** RegWriteD, MemtoRegD, RegDstD and ALUControlD are don't-care when InstrD=0. The decoder outputs 0 for them, and this block applies no extra masking.

## Timing
- **Reset:** rst_n low asynchronously sets PCF=RESET_PC. Every other register output goes to 0, so WriteRegE=0. Counters go to 0.
- **Reset release:** registers update from the first rising edge with rst_n high.
- **Latency:** one cycle per stage. A D-stage instruction presents in E one edge later, in M two edges later, in W three edges later, provided it is not flushed.
- **Stalls and flushes:** a stall holds for exactly the cycles it is asserted. FlushE inserts one bubble per asserted cycle.
- **Reset mid-stall:** clears everything. No state survives.
- **Timing paths:** there is no combinational path from StallF/StallD/FlushE to any output. WriteRegE is combinational from registered E fields only.

## Configuration
- **HAZARD_STATS_EN defined:**
  - StallCount increments on every edge where StallD=1.
  - FlushCount increments on every edge where FlushE=1.
  - Both counters saturate at 16'hFFFF, reset to 0, and are ports of the block.
- **HAZARD_STATS_EN undefined:** the counters and both ports are absent. Pipeline behaviour is identical.

## Test plan
- **Reset:** RESET_PC=32'h0040_0000, rst_n pulsed low mid-cycle -> PCF=32'h0040_0000 immediately, all tags and controls 0, WriteRegE=0.
- **Straight flow:** InstrF=32'h0022_1820 (add $3,$1,$2), RegWriteD=1, RegDstD=1 -> next edge RsD=1, RtD=2, RdD=3; one edge later RsE=1, RtE=2, WriteRegE=3; WriteRegM=3 after 2 edges; RegWriteW=1, WriteRegW=3 after 3 edges.
- **Load-use stall:** StallF=StallD=FlushE=1 for one cycle -> PCF and InstrD unchanged, RegWriteE=0 and RsE=0, previous E contents appear in M.
- **Branch squash:** PCSrcD=1, StallD=0 -> InstrD=0 and RsD=RtD=RdD=0. Then StallD=1 with PCSrcD=1 -> InstrD held.
- **WGHT:** ALUControlD=3'b101, RdD=3, FlushE=0 -> ALUControlE=3'b101, RdE=3. Same stimulus with FlushE=1 -> ALUControlE=0, RdE=0.
- **Stats (HAZARD_STATS_EN defined):** StallD high for 5 edges and FlushE high for 3 edges -> StallCount=5, FlushCount=3. Counter preloaded to 16'hFFFE plus 3 more stalls -> holds 16'hFFFF.
